// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: FSM encodings, handshake levels
// and the zero word used to clear result fields.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider (signed/unsigned), one quotient bit per cycle.
// Optional macro DIV_EARLY_TERM_EN finishes |dividend| < |divisor| in two cycles.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [2*DATA_W-1:0] ZERO_RESULT = {DATA_W'(ZeroWord), DATA_W'(ZeroWord)};

  div_state_e state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   dividend_reg, dividend_next;
  logic [DATA_W-1:0]   divisor_reg, divisor_next;
  logic [DATA_W-1:0]   rem_reg, rem_next;
  logic                neg_q_reg, neg_q_next;
  logic                neg_r_reg, neg_r_next;
  logic [2*DATA_W-1:0] result_reg, result_next;
  logic                ready_reg, ready_next;
`ifdef DIV_EARLY_TERM_EN
  logic [DATA_W-1:0]   orig_reg, orig_next;
  logic                early_reg, early_next;
`endif

  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   shifted, diff;
  logic              step_ok;
  logic [DATA_W-1:0] rem_step, quo_step, q_fix, r_fix;
  logic              last_step;

  assign abs_a = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

  // The dividend register doubles as the quotient: each step shifts one
  // dividend bit into the partial remainder and one quotient bit in at the LSB.
  assign shifted   = {rem_reg, dividend_reg[DATA_W-1]};
  assign diff      = shifted - {1'b0, divisor_reg};
  assign step_ok   = ~diff[DATA_W];
  assign rem_step  = step_ok ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_step  = {dividend_reg[DATA_W-2:0], step_ok};
  assign q_fix     = neg_q_reg ? (~quo_step + 1'b1) : quo_step;
  assign r_fix     = neg_r_reg ? (~rem_step + 1'b1) : rem_step;
  assign last_step = (cnt_reg == CNT_W'(DATA_W - 1));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    dividend_next = dividend_reg;
    divisor_next  = divisor_reg;
    rem_next      = rem_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    result_next   = result_reg;
    ready_next    = ready_reg;
`ifdef DIV_EARLY_TERM_EN
    orig_next     = orig_reg;
    early_next    = early_reg;
`endif

    if (annul_i) begin
      state_next  = DivFree;
      cnt_next    = '0;
      result_next = ZERO_RESULT;
      ready_next  = DivResultNotReady;
    end else begin
      case (state_reg)
        DivFree: begin
          result_next = ZERO_RESULT;
          ready_next  = DivResultNotReady;
          if (start_i == DivStart) begin
            dividend_next = abs_a;
            divisor_next  = abs_b;
            rem_next      = '0;
            cnt_next      = '0;
            neg_q_next    = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r_next    = signed_div_i & opdata1_i[DATA_W-1];
`ifdef DIV_EARLY_TERM_EN
            orig_next     = opdata1_i;
            early_next    = 1'b0;
`endif
            if (opdata2_i == '0) begin
              state_next = DivByZero;
            end
`ifdef DIV_EARLY_TERM_EN
            // Short operations reuse the one-cycle BYZERO hop, flagged by early.
            else if (abs_a < abs_b) begin
              state_next = DivByZero;
              early_next = 1'b1;
            end
`endif
            else begin
              state_next = DivOn;
            end
          end
        end

        DivByZero: begin
          state_next  = DivEnd;
          ready_next  = DivResultReady;
          result_next = ZERO_RESULT;
`ifdef DIV_EARLY_TERM_EN
          if (early_reg) begin
            result_next = {orig_reg, DATA_W'(ZeroWord)};
          end
`endif
        end

        DivOn: begin
          dividend_next = quo_step;
          rem_next      = rem_step;
          cnt_next      = cnt_reg + CNT_W'(1);
          if (last_step) begin
            state_next  = DivEnd;
            cnt_next    = '0;
            result_next = {r_fix, q_fix};
            ready_next  = DivResultReady;
          end
        end

        DivEnd: begin
          if (start_i == DivStop) begin
            state_next  = DivFree;
            result_next = ZERO_RESULT;
            ready_next  = DivResultNotReady;
          end
        end

        default: begin
          state_next  = DivFree;
          result_next = ZERO_RESULT;
          ready_next  = DivResultNotReady;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= DivFree;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      result_reg   <= ZERO_RESULT;
      ready_reg    <= DivResultNotReady;
`ifdef DIV_EARLY_TERM_EN
      orig_reg     <= '0;
      early_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      dividend_reg <= dividend_next;
      divisor_reg  <= divisor_next;
      rem_reg      <= rem_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      result_reg   <= result_next;
      ready_reg    <= ready_next;
`ifdef DIV_EARLY_TERM_EN
      orig_reg     <= orig_next;
      early_reg    <= early_next;
`endif
    end
  end

  assign result_o = result_reg;
  assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized operations
// checked against an arithmetic reference model (longint divide/modulo).
module tb_div_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           signed_div = 1'b0;
  logic [W-1:0]   op1 = '0;
  logic [W-1:0]   op2 = '0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic [2*W-1:0] result;
  logic           ready;

  int tests_run = 0;
  int tests_failed = 0;

  div_iter #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_res(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ma, mb;
    if (b == 32'd0) return 2;
    ma = s ? longint'($signed(a)) : longint'({32'd0, a});
    mb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_TERM_EN
    if (ma < mb) return 2;
`endif
    return (ma < mb) ? W + 1 : W + 1;
  endfunction

  // Drives one operation; lat is the cycle (relative to accept edge N) in which
  // ready is first seen, 0 on timeout.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit scramble, input int hold,
                       output logic [63:0] res, output int lat,
                       output logic [63:0] res_hold, output logic rdy_hold,
                       output logic [63:0] res_drop, output logic rdy_drop);
    op1 = a; op2 = b; signed_div = s; start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      if (scramble) begin
        op1 = $urandom; op2 = $urandom; signed_div = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (ready) begin
        lat = k + 1;
        break;
      end
    end
    res = result;
    repeat (hold) @(posedge clk);
    #1;
    res_hold = result;
    rdy_hold = ready;
    start = 1'b0;
    @(posedge clk);
    #1;
    res_drop = result;
    rdy_drop = ready;
  endtask

  task automatic test_reset();
    logic [63:0] res, rh, rd;
    logic hr, dr;
    int lat;
    rst = 1'b1; start = 1'b1; op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready got=%b want=0", ready); end
    tests_run++;
    if (result !== 64'd0) begin tests_failed++; $display("FAIL reset_result got=%h want=0", result); end
    rst = 1'b0;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 0, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (lat !== W + 1) begin tests_failed++; $display("FAIL first_edge_start_latency got=%0d want=%0d", lat, W + 1); end
    tests_run++;
    if (res !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL first_edge_start_result got=%h want=%h", res, {32'd2, 32'd14}); end
    $display("[TB] reset then 100/7 latency=%0d result=%h", lat, res);
  endtask

  task automatic test_unsigned();
    logic [63:0] res, rh, rd;
    logic hr, dr;
    int lat;
    do_op(32'd100, 32'd7, 1'b0, 1'b0, 3, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (lat !== 33) begin tests_failed++; $display("FAIL unsigned_latency got=%0d want=33", lat); end
    tests_run++;
    if (res !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL unsigned_result got=%h want=%h", res, {32'd2, 32'd14}); end
    tests_run++;
    if (hr !== 1'b1 || rh !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL end_hold got ready=%b res=%h want ready=1 res=%h", hr, rh, {32'd2, 32'd14}); end
    tests_run++;
    if (dr !== 1'b0 || rd !== 64'd0) begin tests_failed++; $display("FAIL start_drop got ready=%b res=%h want ready=0 res=0", dr, rd); end
    $display("[TB] unsigned 100/7 latency=%0d result=%h", lat, res);
  endtask

  task automatic test_signed();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [63:0] te [3];
    logic [63:0] res, rh, rd;
    logic hr, dr;
    int lat;
    ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          te[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  te[1] = {32'd1, 32'hFFFF_FFFD};
    ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;  te[2] = {32'd0, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], 1'b1, 1'b0, 0, res, lat, rh, hr, rd, dr);
      tests_run++;
      if (res !== te[i]) begin tests_failed++; $display("FAIL signed_result[%0d] got=%h want=%h", i, res, te[i]); end
      tests_run++;
      if (lat !== model_lat(ta[i], tb[i], 1'b1)) begin tests_failed++; $display("FAIL signed_latency[%0d] got=%0d want=%0d", i, lat, model_lat(ta[i], tb[i], 1'b1)); end
      $display("[TB] signed %h/%h latency=%0d result=%h", ta[i], tb[i], lat, res);
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res, rh, rd;
    logic hr, dr;
    int lat;
    for (int s = 0; s < 2; s++) begin
      do_op(32'h1234_5678, 32'd0, 1'(s), 1'b0, 1, res, lat, rh, hr, rd, dr);
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL divzero_latency[%0d] got=%0d want=2", s, lat); end
      tests_run++;
      if (res !== 64'd0 || hr !== 1'b1) begin tests_failed++; $display("FAIL divzero_result[%0d] got=%h ready=%b want=0 ready=1", s, res, hr); end
      $display("[TB] divzero signed=%0d latency=%0d result=%h", s, lat, res);
    end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [63:0] res, rh, rd;
    logic hr, dr;
    int lat;
    int seen;
    op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else annul = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (ready !== 1'b0 || result !== 64'd0) begin tests_failed++; $display("FAIL abort_now[%0d] got ready=%b res=%h want 0/0", use_rst, ready, result); end
    rst = 1'b0; annul = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (ready) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL abort_quiet[%0d] got ready_cycles=%0d want=0", use_rst, seen); end
    if (!use_rst) begin
      start = 1'b1; annul = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (ready !== 1'b0) begin tests_failed++; $display("FAIL annul_priority got ready=%b want=0", ready); end
      annul = 1'b0; start = 1'b0;
      @(posedge clk);
      #1;
    end
    do_op(32'd5, 32'd5, 1'b0, 1'b0, 0, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (res !== {32'd0, 32'd1}) begin tests_failed++; $display("FAIL after_abort[%0d] got=%h want=%h", use_rst, res, {32'd0, 32'd1}); end
    $display("[TB] abort via %s then 5/5 result=%h", use_rst ? "rst" : "annul", res);
  endtask

  task automatic test_early_term();
    logic [63:0] res, rh, rd;
    logic hr, dr;
    int lat;
    do_op(32'd3, 32'd10, 1'b0, 1'b0, 0, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (res !== {32'd3, 32'd0}) begin tests_failed++; $display("FAIL early_result got=%h want=%h", res, {32'd3, 32'd0}); end
    tests_run++;
`ifdef DIV_EARLY_TERM_EN
    if (lat !== 2) begin tests_failed++; $display("FAIL early_latency got=%0d want=2", lat); end
`else
    if (lat !== 33) begin tests_failed++; $display("FAIL early_latency got=%0d want=33", lat); end
`endif
    $display("[TB] 3/10 latency=%0d result=%h", lat, res);
    do_op(32'hFFFF_FFFD, 32'd10, 1'b1, 1'b0, 0, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (res !== {32'hFFFF_FFFD, 32'd0}) begin tests_failed++; $display("FAIL early_signed got=%h want=%h", res, {32'hFFFF_FFFD, 32'd0}); end
    do_op(32'd100, 32'd7, 1'b0, 1'b1, 0, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (res !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL operand_change got=%h want=%h", res, {32'd2, 32'd14}); end
    do_op(32'd3, 32'd10, 1'b0, 1'b1, 0, res, lat, rh, hr, rd, dr);
    tests_run++;
    if (res !== {32'd3, 32'd0}) begin tests_failed++; $display("FAIL operand_change_short got=%h want=%h", res, {32'd3, 32'd0}); end
    $display("[TB] operand scramble during ON result=%h", res);
  endtask

  task automatic test_random();
    logic [63:0] res, rh, rd, exp_res;
    logic hr, dr;
    logic [31:0] a, b;
    logic s;
    int lat, exp_lat, sel;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel < 4) b = 32'($urandom_range(1, 300));
      else if (sel == 4) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      else b = $urandom;
      if (sel == 5) a = 32'($urandom_range(0, 50));
      s = 1'($urandom_range(0, 1));
      exp_res = model_res(a, b, s);
      exp_lat = model_lat(a, b, s);
      do_op(a, b, s, 1'(i % 2), 0, res, lat, rh, hr, rd, dr);
      tests_run++;
      if (res !== exp_res || lat !== exp_lat) begin
        tests_failed++;
        $display("FAIL random[%0d] %h/%h s=%0d got=%h lat=%0d want=%h lat=%0d", i, a, b, s, res, lat, exp_res, exp_lat);
      end
      $display("[TB] random %h/%h s=%0d latency=%0d result=%h", a, b, s, lat, res);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_abort(1'b0);
    test_abort(1'b1);
    test_early_term();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
